// File: rtl/bch_syndrome_parallel_pkg.sv
// GF(2^M) helpers shared by the syndrome generator: field polynomials and
// constant-foldable power/multiply functions.
package bch_syndrome_parallel_pkg;
  localparam int GF_W = 32;
  typedef logic [GF_W-1:0] gf_t;

  // Primitive polynomials, x^M term included.
  function automatic gf_t gf_poly(input int m);
    case (m)
      2:       return 32'h7;
      3:       return 32'hB;
      4:       return 32'h13;
      5:       return 32'h25;
      6:       return 32'h43;
      7:       return 32'h89;
      8:       return 32'h11D;
      9:       return 32'h211;
      10:      return 32'h409;
      11:      return 32'h805;
      12:      return 32'h1053;
      13:      return 32'h201B;
      14:      return 32'h4443;
      15:      return 32'h8003;
      default: return 32'h13;
    endcase
  endfunction

  function automatic gf_t gf_mulx(input gf_t a, input int m);
    gf_t r;
    r = a << 1;
    if (r[m]) r = r ^ gf_poly(m);
    return r;
  endfunction

  function automatic gf_t lpow(input int m, input int e);
    gf_t r;
    int  n;
    r = 1;
    n = e % ((1 << m) - 1);
    for (int i = 0; i < n; i++) r = gf_mulx(r, m);
    return r;
  endfunction

  function automatic gf_t gf_mul(input gf_t a, input gf_t b, input int m);
    gf_t r;
    r = '0;
    for (int i = m - 1; i >= 0; i--) begin
      r = gf_mulx(r, m);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/bch_syndrome_parallel_if.sv
// Codeword beat stream in, syndrome bundle out.
interface bch_syndrome_parallel_if #(
  parameter int M    = 4,
  parameter int T    = 3,
  parameter int BITS = 1
);
  logic              in_valid;
  logic              in_ready;
  logic [BITS-1:0]   data_in;
  logic              flush;
  logic              syn_valid;
  logic              syn_ready;
  logic [2*T*M-1:0]  syn;
  logic              syn_zero;

  modport master (
    output in_valid, data_in, flush, syn_ready,
    input  in_ready, syn_valid, syn, syn_zero
  );
  modport slave (
    input  in_valid, data_in, flush, syn_ready,
    output in_ready, syn_valid, syn, syn_zero
  );
endinterface

// File: rtl/bch_syndrome_lane.sv
// One syndrome S_J: Horner accumulator stepping by alpha^(J*BITS) per beat.
module bch_syndrome_lane
  import bch_syndrome_parallel_pkg::*;
#(
  parameter int M    = 4,
  parameter int J    = 1,
  parameter int BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic            first,
  input  logic [BITS-1:0] d,
  output logic [M-1:0]    acc_nxt
);
  localparam logic [M-1:0] FB = M'(lpow(M, J * BITS));

  logic [M-1:0]           acc;
  logic [BITS-1:0][M-1:0] pw;

  // alpha^(J*k) weights for each bit position of the beat
  for (genvar k = 0; k < BITS; k++) begin : g_pw
    localparam logic [M-1:0] PK = M'(lpow(M, J * k));
    assign pw[k] = PK;
  end

  always_comb begin
    acc_nxt = first ? '0 : M'(gf_mul(gf_t'(acc), gf_t'(FB), M));
    for (int k = 0; k < BITS; k++)
      if (d[k]) acc_nxt = acc_nxt ^ pw[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc_nxt;
  end
endmodule

// File: rtl/bch_syndrome_parallel.sv
// Parallel BCH syndrome generator: 2T lanes fed BITS codeword bits per beat,
// result double-buffered so the next codeword streams while S is held.
module bch_syndrome_parallel
  import bch_syndrome_parallel_pkg::*;
#(
  parameter int M    = 4,
  parameter int T    = 3,
  parameter int N    = (1 << M) - 1,
  parameter int BITS = 1
) (
  input  logic clk,
  input  logic rst_n,
  bch_syndrome_parallel_if.slave bus
);
  localparam int NSYN  = 2 * T;
  localparam int BEATS = ceil_div(N, BITS);
  localparam int PAD   = BEATS * BITS - N;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Pad bits sit above degree N-1 in the first beat and are forced to zero.
  localparam logic [BITS-1:0] FIRST_MASK = {BITS{1'b1}} >> PAD;

  logic [CW-1:0]          cnt;
  logic                   first, last, accept;
  logic [BITS-1:0]        d;
  logic [NSYN-1:0][M-1:0] acc_nxt;
  logic [NSYN-1:0][M-1:0] syn_q;
  logic                   syn_valid_q, syn_zero_q;

  assign first        = (cnt == '0);
  assign last         = (cnt == CW'(BEATS - 1));
  assign bus.in_ready = ~(last & syn_valid_q & ~bus.syn_ready);
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
  assign d            = first ? (bus.data_in & FIRST_MASK) : bus.data_in;

  for (genvar g = 0; g < NSYN; g++) begin : g_lane
    bch_syndrome_lane #(.M(M), .J(g + 1), .BITS(BITS)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (accept),
      .clr     (bus.flush),
      .first   (first),
      .d       (d),
      .acc_nxt (acc_nxt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (bus.flush) cnt <= '0;
    else if (accept)    cnt <= last ? '0 : cnt + 1'b1;
  end

  // Last beat loads straight from the lane adders; a same-cycle consume is
  // absorbed because the new result simply replaces the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syn_q       <= '0;
      syn_valid_q <= 1'b0;
      syn_zero_q  <= 1'b0;
    end else if (accept && last) begin
      syn_q       <= acc_nxt;
      syn_valid_q <= 1'b1;
      syn_zero_q  <= ~|acc_nxt;
    end else if (syn_valid_q && bus.syn_ready) begin
      syn_valid_q <= 1'b0;
    end
  end

  assign bus.syn       = syn_q;
  assign bus.syn_valid = syn_valid_q;
  assign bus.syn_zero  = syn_zero_q;
endmodule

// File: tb/tb_bch_syndrome_parallel.sv
// Directed + table-driven checks of the syndrome generator, BITS=1 and BITS=4.
module tb_bch_syndrome_parallel;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bch_syndrome_parallel_if #(.M(4), .T(3), .BITS(1)) b1 ();
  bch_syndrome_parallel_if #(.M(4), .T(3), .BITS(4)) b4 ();

  bch_syndrome_parallel #(.M(4), .T(3), .N(15), .BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  bch_syndrome_parallel #(.M(4), .T(3), .N(15), .BITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stall_sum = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [14:0] cw;
    logic [23:0] syn;
    logic        zero;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Direct evaluation S_j = sum r_i * alpha^(i*j), field x^4+x+1.
  function automatic logic [23:0] ref_syn(input logic [14:0] cw);
    logic [3:0]  apow [15];
    logic [23:0] s;
    apow = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
             4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};
    s = '0;
    for (int j = 1; j <= 6; j++)
      for (int i = 0; i < 15; i++)
        if (cw[i]) s[(j-1)*4 +: 4] = s[(j-1)*4 +: 4] ^ apow[(i*j) % 15];
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic beat1(input logic dv);
    int w = 0;
    b1.in_valid = 1'b1;
    b1.data_in  = dv;
    while (!b1.in_ready && w < 64) begin @(negedge clk); w++; end
    stall_sum += w;
    if (w >= 64) begin total++; bad++; $display("FAIL beat1_timeout waited=%0d limit=64", w); end
    @(negedge clk);
  endtask

  task automatic beat4(input logic [3:0] dv);
    int w = 0;
    b4.in_valid = 1'b1;
    b4.data_in  = dv;
    while (!b4.in_ready && w < 64) begin @(negedge clk); w++; end
    stall_sum += w;
    if (w >= 64) begin total++; bad++; $display("FAIL beat4_timeout waited=%0d limit=64", w); end
    @(negedge clk);
  endtask

  logic pre_v;
  task automatic send1(input logic [14:0] cw);
    for (int i = 14; i >= 0; i--) begin
      if (i == 0) pre_v = b1.syn_valid;
      beat1(cw[i]);
    end
    b1.in_valid = 1'b0;
  endtask

  task automatic send4(input logic [14:0] cw, input logic pad);
    logic [15:0] w;
    w = {pad, cw};
    for (int b = 3; b >= 0; b--) beat4(w[b*4 +: 4]);
    b4.in_valid = 1'b0;
  endtask

  initial begin
    logic [14:0] cw, cwa, cwb;
    logic [15:0] wb;
    logic [23:0] e;
    int c0;

    b1.in_valid = 0; b1.data_in = '0; b1.flush = 0; b1.syn_ready = 1;
    b4.in_valid = 0; b4.data_in = '0; b4.flush = 0; b4.syn_ready = 1;

    vecs[0] = '{15'h0000, 24'h000000, 1'b1};
    vecs[1] = '{15'h0001, 24'h111111, 1'b0};
    vecs[2] = '{15'h0002, 24'hC63842, 1'b0};
    vecs[3] = '{15'h4000, 24'hA7EFD9, 1'b0};
    vecs[4] = '{15'h0537, 24'h000000, 1'b1};
    vecs[5] = '{15'h0003, 24'hD72953, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_valid1", b1.syn_valid, 0);
    chk("rst_syn1",   b1.syn, 0);
    chk("rst_zero1",  b1.syn_zero, 0);
    chk("rst_ready1", b1.in_ready, 1);
    chk("rst_valid4", b4.syn_valid, 0);
    chk("rst_ready4", b4.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors; BITS=4 runs use a set pad bit that must be masked.
    for (int i = 0; i < 6; i++) begin
      send1(vecs[i].cw);
      chk($sformatf("tbl%0d_prelast1", i), pre_v, 0);
      chk($sformatf("tbl%0d_valid1", i), b1.syn_valid, 1);
      chk($sformatf("tbl%0d_syn1", i),   b1.syn, vecs[i].syn);
      chk($sformatf("tbl%0d_zero1", i),  b1.syn_zero, vecs[i].zero);
      @(negedge clk);
      chk($sformatf("tbl%0d_drop1", i),  b1.syn_valid, 0);
      send4(vecs[i].cw, 1'b1);
      chk($sformatf("tbl%0d_valid4", i), b4.syn_valid, 1);
      chk($sformatf("tbl%0d_syn4", i),   b4.syn, vecs[i].syn);
      chk($sformatf("tbl%0d_zero4", i),  b4.syn_zero, vecs[i].zero);
      @(negedge clk);
    end

    for (int i = 0; i < 6; i++) begin
      cw = 15'($urandom_range(0, 32767));
      e  = ref_syn(cw);
      send1(cw);
      chk($sformatf("rnd%0d_syn1", i), b1.syn, e);
      @(negedge clk);
      send4(cw, 1'($urandom_range(0, 1)));
      chk($sformatf("rnd%0d_syn4", i), b4.syn, e);
      @(negedge clk);
    end

    // Back-to-back codewords, no bubble.
    cwa = 15'h1234; cwb = 15'h0537 ^ 15'h0100;
    stall_sum = 0;
    c0 = cyc;
    send4(cwa, 1'b0);
    chk("b2b_synA", b4.syn, ref_syn(cwa));
    send4(cwb, 1'b0);
    chk("b2b_synB", b4.syn, ref_syn(cwb));
    chk("b2b_cycles", cyc - c0, 8);
    chk("b2b_stalls", stall_sum, 0);
    @(negedge clk);

    // Backpressure: hold A, stream B up to its last beat.
    cwa = 15'h0F0F; cwb = 15'h7001;
    b4.syn_ready = 1'b0;
    send4(cwa, 1'b0);
    chk("bp_validA", b4.syn_valid, 1);
    chk("bp_synA",   b4.syn, ref_syn(cwa));
    stall_sum = 0;
    wb = {1'b0, cwb};
    beat4(wb[15:12]); beat4(wb[11:8]); beat4(wb[7:4]);
    chk("bp_nostall", stall_sum, 0);
    b4.in_valid = 1'b1;
    b4.data_in  = wb[3:0];
    #1;
    chk("bp_ready_lo0", b4.in_ready, 0);
    repeat (3) @(negedge clk);
    chk("bp_ready_lo3", b4.in_ready, 0);
    chk("bp_syn_hold",  b4.syn, ref_syn(cwa));
    chk("bp_valid_hold", b4.syn_valid, 1);
    b4.syn_ready = 1'b1;
    @(negedge clk);
    b4.in_valid = 1'b0;
    chk("bp_validB", b4.syn_valid, 1);
    chk("bp_synB",   b4.syn, ref_syn(cwb));
    @(negedge clk);
    chk("bp_dropB",  b4.syn_valid, 0);

    // Flush at beat 7, then a clean r_0=1 codeword.
    for (int i = 0; i < 7; i++) beat1(1'b1);
    b1.in_valid = 1'b1; b1.data_in = 1'b1; b1.flush = 1'b1;
    @(negedge clk);
    b1.flush = 1'b0; b1.in_valid = 1'b0;
    chk("fl_novalid", b1.syn_valid, 0);
    send1(15'h0001);
    chk("fl_valid", b1.syn_valid, 1);
    chk("fl_syn",   b1.syn, 24'h111111);
    chk("fl_zero",  b1.syn_zero, 0);
    @(negedge clk);

    // Reset mid-codeword.
    for (int i = 0; i < 5; i++) beat1(1'b1);
    b1.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mr_syn",   b1.syn, 0);
    chk("mr_valid", b1.syn_valid, 0);
    chk("mr_zero",  b1.syn_zero, 0);
    chk("mr_ready", b1.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_noout", b1.syn_valid, 0);
    send1(15'h0002);
    chk("mr_syn_after", b1.syn, 24'hC63842);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
